// File: rtl/if_id_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer_pkg
//  Description : Shared types and constants for the fetch-to-decode buffer:
//                instruction bus types, reset/valid levels and the packed
//                entry layout stored in the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_id_buffer_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    // Instruction address bus and instruction word bus (both 31:0)
    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
    typedef logic [INST_W-1:0]      inst_bus_t;

    // Level at which the active-low reset is asserted
    localparam logic RESET_ACTIVE_N = 1'b0;

    localparam logic VALID_TRUE  = 1'b1;
    localparam logic VALID_FALSE = 1'b0;

    // One queued fetch: address, instruction word and the alignment tag
    typedef struct packed {
        inst_addr_bus_t pc;
        inst_bus_t      inst;
        logic           misaligned;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // A PC is misaligned when it does not sit on a 32-bit word boundary
    function automatic logic pc_misaligned(input inst_addr_bus_t pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage : if_id_buffer_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_mem
//  Description : DEPTH x WIDTH register array with one synchronous write
//                port and one combinational read port. Contents are not
//                reset; validity is tracked by the owner of the pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1,
    parameter int WIDTH  = 65
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an enabled clock edge
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed entry
    always_comb begin
        rdata = mem[raddr];
    end

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer
//  Description : Fetch-to-decode decoupling FIFO. Queues {pc, inst} pairs
//                from fetch, presents the head to decode over valid/ready,
//                back-pressures fetch when full, discards everything on
//                flush and tags word-misaligned PCs.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 if_valid,
    input  logic [31:0]          if_pc,
    input  logic [31:0]          if_inst,
    output logic                 if_ready,
    output logic                 id_valid,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_inst,
    output logic                 id_misaligned,
    input  logic                 id_ready,
    output logic [PTR_W:0]       occupancy
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    // Reject geometries the pointer arithmetic cannot wrap correctly
    if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_param_check
        $error("if_id_buffer: DEPTH must be a power of two >= 2 and PTR_W = log2(DEPTH)");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    logic [ENTRY_W-1:0] rd_bits;
    fetch_entry_t     rd_entry;

    // Handshake qualification; ready depends only on registered count so
    // no combinational path runs from id_ready back to if_ready
    always_comb begin
        if_ready  = (count != FULL_COUNT);
        id_valid  = (count != '0) ? VALID_TRUE : VALID_FALSE;
        push      = if_valid & if_ready & ~flush;
        pop       = id_valid & id_ready & ~flush;
        occupancy = count;
    end

    // Build the stored entry, including the alignment tag
    always_comb begin
        wr_entry.pc         = if_pc;
        wr_entry.inst       = if_inst;
        wr_entry.misaligned = pc_misaligned(if_pc);
    end

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W),
        .WIDTH  (ENTRY_W)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_bits)
    );

    // Head entry is zeroed whenever nothing valid is held
    always_comb begin
        rd_entry      = fetch_entry_t'(rd_bits);
        id_pc         = id_valid ? rd_entry.pc         : '0;
        id_inst       = id_valid ? rd_entry.inst       : '0;
        id_misaligned = id_valid ? rd_entry.misaligned : 1'b0;
    end

    // Pointer and count bookkeeping; reset dominates flush
    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ACTIVE_N) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Occupancy bound and handshake legality
    a_count_bound : assert property (@(posedge clock) disable iff (!reset)
        count <= FULL_COUNT);
    a_no_push_full : assert property (@(posedge clock) disable iff (!reset)
        (count == FULL_COUNT) |-> !push);
    a_no_pop_empty : assert property (@(posedge clock) disable iff (!reset)
        (count == '0) |-> !pop);

endmodule : if_id_buffer
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Directed self-checking bench for if_id_buffer (DEPTH=2).
//                Inputs change and outputs are sampled 1 ns after each
//                rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_misaligned;
    logic        id_ready;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_buffer #(
        .DEPTH (2),
        .PTR_W (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_ready      (if_ready),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_misaligned (id_misaligned),
        .id_ready      (id_ready),
        .occupancy     (occupancy)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
    endtask

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset state (asserted before any clock edge)
        #3;
        check("rst_id_valid",   32'(id_valid),      32'd0);
        check("rst_if_ready",   32'(if_ready),      32'd1);
        check("rst_occupancy",  32'(occupancy),     32'd0);
        check("rst_id_pc",      id_pc,              32'h0);
        check("rst_id_inst",    id_inst,            32'h0);
        check("rst_misaligned", 32'(id_misaligned), 32'd0);
        step();
        reset = 1'b1;

        // 1: single push, visible next cycle, consumed the cycle after
        drive(1'b1, 32'h0000_0000, 32'h3401_1100, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t1_id_valid", 32'(id_valid), 32'd1);
        check("t1_id_pc",    id_pc,         32'h0000_0000);
        check("t1_id_inst",  id_inst,       32'h3401_1100);
        check("t1_occ",      32'(occupancy), 32'd1);
        step();
        check("t1_drained_valid", 32'(id_valid),  32'd0);
        check("t1_drained_occ",   32'(occupancy), 32'd0);

        // 2: fill while decode stalls, third item held at fetch
        drive(1'b1, 32'h0, 32'hA000_0000, 1'b0);
        step();
        drive(1'b1, 32'h4, 32'hA000_0004, 1'b0);
        step();
        check("t2_full_occ",   32'(occupancy), 32'd2);
        check("t2_full_ready", 32'(if_ready),  32'd0);
        drive(1'b1, 32'h8, 32'hA000_0008, 1'b0);
        step();
        check("t2_held_occ", 32'(occupancy), 32'd2);
        check("t2_head0_pc", id_pc,          32'h0);
        check("t2_head0_inst", id_inst,      32'hA000_0000);
        drive(1'b1, 32'h8, 32'hA000_0008, 1'b1);
        step();
        check("t2_head1_pc", id_pc,         32'h4);
        check("t2_ready_back", 32'(if_ready), 32'd1);
        check("t2_occ_after_pop", 32'(occupancy), 32'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t2_head2_pc",   id_pc,   32'h8);
        check("t2_head2_inst", id_inst, 32'hA000_0008);
        check("t2_occ_steady", 32'(occupancy), 32'd1);
        step();
        check("t2_empty", 32'(id_valid), 32'd0);

        // 3: streaming push+pop across pointer wrap
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 32'h0000_1000 + 32'(i), 1'b1);
            step();
            check($sformatf("t3_pc_%0d", i),   id_pc,          32'(i * 4));
            check($sformatf("t3_inst_%0d", i), id_inst,        32'h0000_1000 + 32'(i));
            check($sformatf("t3_occ_%0d", i),  32'(occupancy), 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        step();
        check("t3_drained", 32'(occupancy), 32'd0);

        // 4: flush discards queued entries and the same-cycle push
        drive(1'b1, 32'h10, 32'hB000_0010, 1'b0);
        step();
        drive(1'b1, 32'h14, 32'hB000_0014, 1'b0);
        step();
        check("t4_full_occ", 32'(occupancy), 32'd2);
        drive(1'b1, 32'h18, 32'hB000_0018, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t4_valid_after_flush", 32'(id_valid),  32'd0);
        check("t4_occ_after_flush",   32'(occupancy), 32'd0);
        check("t4_ready_after_flush", 32'(if_ready),  32'd1);
        step();
        check("t4_no_0x18", 32'(id_valid), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_flush_empty_occ", 32'(occupancy), 32'd0);

        // 5: misalignment tag follows the head entry
        drive(1'b1, 32'h6, 32'hC000_0006, 1'b0);
        step();
        check("t5_mis_pc",  id_pc,               32'h6);
        check("t5_mis_tag", 32'(id_misaligned),  32'd1);
        drive(1'b1, 32'h8, 32'hC000_0008, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t5_al_pc",  id_pc,              32'h8);
        check("t5_al_tag", 32'(id_misaligned), 32'd0);
        step();
        check("t5_drained", 32'(occupancy), 32'd0);

        // 6: asynchronous reset while full, then first push lands at slot 0
        drive(1'b1, 32'h100, 32'hD000_0100, 1'b0);
        step();
        drive(1'b1, 32'h104, 32'hD000_0104, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("t6_full_occ", 32'(occupancy), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_valid", 32'(id_valid),  32'd0);
        check("t6_async_ready", 32'(if_ready),  32'd1);
        check("t6_async_occ",   32'(occupancy), 32'd0);
        check("t6_async_pc",    id_pc,          32'h0);
        step();
        reset = 1'b1;
        drive(1'b1, 32'h20, 32'hE000_0020, 1'b0);
        step();
        check("t6_first_pc",   id_pc,   32'h20);
        check("t6_first_inst", id_inst, 32'hE000_0020);
        check("t6_first_occ",  32'(occupancy), 32'd1);
        drive(1'b1, 32'h24, 32'hE000_0024, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("t6_still_head", id_pc, 32'h20);
        step();
        check("t6_second_pc", id_pc, 32'h24);
        step();
        check("t6_end_empty", 32'(id_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_id_buffer
`default_nettype wire

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Fetch-to-decode decoupling stage, directly downstream of the PC register and instruction ROM.
- Captures each fetched {pc, instruction} pair into a small in-order FIFO and presents it to the ID stage over a valid/ready handshake.
- Back-pressures fetch when full, and discards all queued entries on a pipeline flush (branch/exception redirect).
- Tags each entry whose PC is not word-aligned, so decode can raise an address-error exception.

Parameters:
- DEPTH, 2, number of queued entries; power of two, minimum 2.
- PTR_W, 1, pointer width; must equal log2(DEPTH).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately, released synchronously by the system.
- flush  input  1  synchronous discard of all queued entries and of this cycle's push.
- if_valid  input  1  fetch presents a valid pc/inst this cycle.
- if_pc  input  32  fetch address.
- if_inst  input  32  instruction word from ROM.
- if_ready  output  1  buffer can accept a push this cycle.
- id_valid  output  1  head entry valid for decode.
- id_pc  output  32  head entry PC.
- id_inst  output  32  head entry instruction.
- id_misaligned  output  1  head entry PC[1:0] != 0.
- id_ready  input  1  decode consumes head this cycle.
- occupancy  output  PTR_W+1  number of entries held, for debug and perf counters.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0.
  - id_valid=0, if_ready=1, occupancy=0.
  - id_pc=0, id_inst=0, id_misaligned=0.
  - Storage array is not reset.
- Push: push = if_valid & if_ready & ~flush. Writes {if_pc, if_inst, if_pc[1:0]!=0} at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: pop = id_valid & id_ready & ~flush; rd_ptr increments mod DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- if_ready = (count != DEPTH), combinational from registered count. No dependence on id_ready, so there is no ready-path combinational loop.
- id_valid = (count != 0). id_pc/id_inst/id_misaligned are a combinational read of the entry at rd_ptr; they are forced to 0 when id_valid=0.
- Latency:
  - Item pushed at cycle N is visible at id_* in cycle N+1 if the buffer was empty.
  - There is no same-cycle bypass.
  - Throughput is 1 item/cycle when id_ready stays high.
- Full, with pop asserted: if_ready=0, so no push that cycle. if_ready returns to 1 the following cycle.
- Empty, with id_ready asserted: no pop; count stays 0.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Ordering is strictly FIFO across the wrap.
- Flush:
  - Takes effect at the next edge: count=0, wr_ptr=rd_ptr=0.
  - Same-cycle push and pop are both suppressed.
  - id_valid=0 in the cycle after flush.
  - Flush while empty is harmless.
- flush and reset together: reset dominates.
- Reset asserted mid-operation: all entries are lost immediately; the first push after reset release lands at pointer 0.
- Held-data stability: while id_valid=1 and id_ready=0, id_pc/id_inst/id_misaligned must not change.
- Assertions for the verifier:
  - count never exceeds DEPTH.
  - No push when full.
  - No pop when empty.

Decomposition:
- Shared defines file:
  - InstAddrBus and InstBus (both 31:0).
  - ResetActive_n = 1'b0.
  - ValidTrue/ValidFalse.
- Existing active-high ResetEnable/ChipEnable macros stay untouched; this block uses only ResetActive_n.
- One sub-module, sync_fifo_mem: a DEPTH x 65-bit register array with a write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- Pointer, count and handshake logic stays in if_id_buffer.

Test Plan:
1. Reset release, id_ready=1, one push of pc=0x00000000, inst=0x34011100 -> next cycle id_valid=1, id_pc=0x0, id_inst=0x34011100; the cycle after, id_valid=0, occupancy=0.
2. id_ready=0, push pc 0x0, 0x4, 0x8 on consecutive cycles -> occupancy reaches 2 and if_ready=0 after the second push. Third item is held at fetch and accepted once id_ready=1. Drain order 0x0, 0x4, 0x8.
3. Continuous push and pop for 8 cycles with PCs 0x0..0x1C -> occupancy stays 1, every PC is emitted once in order, and pointers wrap correctly.
4. Buffer holds 0x10 and 0x14; assert flush together with if_valid (pc 0x18) and id_ready -> next cycle id_valid=0, occupancy=0, and 0x18 is never emitted.
5. Push pc=0x00000006 -> id_misaligned=1 with id_pc=0x6. A following push of pc=0x8 gives id_misaligned=0.
6. Buffer full, drive reset=0 asynchronously between clock edges -> id_valid=0, if_ready=1, occupancy=0 without waiting for a clock edge. After release, push 0x20 -> emitted first.
